toggle_counter: RTL and testbench
=================================

TOGGLE_COUNTER -- requirements
Module: toggle_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bit width of the toggle register (legal 1..32).
REQ-002 The block SHALL have parameter MODULUS, default 256, giving the count range 0..MODULUS-1 (legal 2..2**WIDTH).
REQ-003 The block SHALL have parameter WRAP, default 1, where 1 means wrap at the range ends and 0 means saturate.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset: asynchronous, active-low.
REQ-006 The block SHALL have port en, input, 1 bit, the operation enable sampled at the clk rising edge.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 toggle, 01 count up, 10 count down, 11 load.
REQ-008 The block SHALL have port t_mask, input, WIDTH bits, the per-bit toggle enables used in toggle mode.
REQ-009 The block SHALL have port load_val, input, WIDTH bits, the value written in load mode.
REQ-010 The block SHALL have port clr_ovf, input, 1 bit, a synchronous clear of the sticky overflow flag.
REQ-011 The block SHALL have port q, output, WIDTH bits, the registered counter/toggle state.
REQ-012 The block SHALL have port tc, output, 1 bit, a registered terminal-count pulse.
REQ-013 The block SHALL have port ovf, output, 1 bit, a registered sticky overflow/range flag.

Function
REQ-014 With en=0, q SHALL hold and tc SHALL be 0 on the next edge; ovf SHALL hold except for clr_ovf.
REQ-015 In toggle mode (en=1, mode=00), each bit q[i] SHALL invert when t_mask[i]=1 and hold otherwise, using one shared edge for all bits.
REQ-016 In toggle mode, a result of MODULUS or more SHALL instead load MODULUS-1 and set ovf; tc SHALL be 0.
REQ-017 In up mode, if q<MODULUS-1 then q SHALL become q+1 with tc=0.
REQ-018 In up mode at q=MODULUS-1, q SHALL become 0 when WRAP=1 or hold when WRAP=0; tc SHALL be 1 for one cycle and ovf SHALL set.
REQ-019 In down mode, if q>0 then q SHALL become q-1 with tc=0.
REQ-020 In down mode at q=0, q SHALL become MODULUS-1 when WRAP=1 or hold at 0 when WRAP=0; tc SHALL be 1 for one cycle and ovf SHALL set.
REQ-021 In load mode, q SHALL take load_val when load_val<MODULUS; otherwise q SHALL take MODULUS-1 and ovf SHALL set; tc SHALL be 0.
REQ-022 tc SHALL be high only in the cycle following the edge that performed a wrap or saturation attempt.
REQ-023 While saturated with WRAP=0 and up/down held, tc SHALL pulse on every enabled edge.
REQ-024 ovf SHALL clear when clr_ovf=1, independent of en, on the next edge.
REQ-025 If a set event and clr_ovf=1 occur on the same edge, set SHALL win and ovf SHALL be 1.
REQ-026 All arithmetic SHALL be modulo-range checked at WIDTH bits with no carry out of bit WIDTH-1.
REQ-027 No combinational path SHALL exist from any input to q, tc or ovf.
REQ-028 With WIDTH=1 and MODULUS=2, up mode with en as T SHALL behave exactly as a single toggle flip-flop.

Reset
REQ-029 rst=0 SHALL force q=0, tc=0 and ovf=0 immediately, without waiting for clk.
REQ-030 While rst=0, all inputs SHALL be ignored.
REQ-031 Reset asserted mid-count SHALL abandon the operation, with no tc pulse on release.
REQ-032 The first enabled edge after rst rises SHALL operate from q=0.

Verification (WIDTH=4, MODULUS=10 unless noted)
REQ-033 Up wrap: WRAP=1, en=1, mode=01, 12 edges from reset -> q=1..9,0,1,2, with tc=1 only after the 10th edge and ovf=1 from then.
REQ-034 Down saturate: WRAP=0, load 1, then mode=10 for 3 edges -> q=0,0,0, with tc pulsing on the 2nd and 3rd edges.
REQ-035 Toggle: q=0101, t_mask=0011 -> q=0110; then t_mask=1100 -> result 1010 (10) clamps to q=1001 (9), ovf=1.
REQ-036 Load range: load_val=7 -> q=7, ovf unchanged; load_val=15 -> q=9, ovf=1; clr_ovf=1 with en=0 -> ovf=0.
REQ-037 Priority and reset: clr_ovf=1 on the wrap edge -> ovf=1; rst pulsed low between edges at q=6 -> q=0, tc=0, ovf=0 before the next clk.
REQ-038 TFF equivalence: WIDTH=1, MODULUS=2, mode=01, en pattern 1,0,1,1 -> q=1,1,0,1.

Source files
------------

// File: rtl/toggle_counter.sv
// Multi-mode register: per-bit toggle, up/down count, or load, all clamped to 0..MODULUS-1.
// Outputs are registered: q, a one-cycle terminal-count pulse tc, and a sticky overflow flag ovf.
module toggle_counter #(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MODULUS = 256,
  parameter bit              WRAP    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t_mask,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  typedef enum logic [1:0] {
    ModeToggle = 2'b00,
    ModeUp     = 2'b01,
    ModeDown   = 2'b10,
    ModeLoad   = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] toggled;
  logic             tc_d;
  logic             ovf_set;
  logic             ovf_d;

  always_comb begin
    q_d     = q;
    tc_d    = 1'b0;
    ovf_set = 1'b0;
    toggled = q ^ t_mask;
    if (en) begin
      unique case (mode_e'(mode))
        ModeToggle: begin
          // Range check is done in 64 bits so MODULUS == 2**WIDTH never truncates.
          if (64'(toggled) >= MODULUS) begin
            q_d     = MaxVal;
            ovf_set = 1'b1;
          end else begin
            q_d = toggled;
          end
        end
        ModeUp: begin
          if (q == MaxVal) begin
            q_d     = WRAP ? '0 : q;
            tc_d    = 1'b1;
            ovf_set = 1'b1;
          end else begin
            q_d = q + WIDTH'(1);
          end
        end
        ModeDown: begin
          if (q == '0) begin
            q_d     = WRAP ? MaxVal : '0;
            tc_d    = 1'b1;
            ovf_set = 1'b1;
          end else begin
            q_d = q - WIDTH'(1);
          end
        end
        ModeLoad: begin
          if (64'(load_val) >= MODULUS) begin
            q_d     = MaxVal;
            ovf_set = 1'b1;
          end else begin
            q_d = load_val;
          end
        end
        default: q_d = q;
      endcase
    end
    // A set event on the same edge as a clear leaves the flag set.
    ovf_d = ovf_set | (ovf & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      q   <= q_d;
      tc  <= tc_d;
      ovf <= ovf_d;
    end
  end

endmodule

// File: tb/tb_toggle_counter.sv
// Self-checking bench for toggle_counter: three instances (wrap, saturate, 1-bit TFF)
// driven cycle by cycle with expectations queued in a scoreboard.
module tb_toggle_counter;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [3:0] mask;
    logic [3:0] load;
    logic       clr;
    logic [3:0] q;
    logic       tc;
    logic       ovf;
  } step_t;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic       tc;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_en = 0, a_clr = 0, a_tc, a_ovf;
  logic [1:0] a_mode = 0;
  logic [3:0] a_mask = 0, a_load = 0, a_q;

  logic       b_en = 0, b_clr = 0, b_tc, b_ovf;
  logic [1:0] b_mode = 0;
  logic [3:0] b_mask = 0, b_load = 0, b_q;

  logic       c_en = 0, c_clr = 0, c_tc, c_ovf;
  logic [1:0] c_mode = 2'b01;
  logic [0:0] c_mask = 0, c_load = 0, c_q;

  always #5 clk = ~clk;

  toggle_counter #(.WIDTH(4), .MODULUS(10), .WRAP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(a_en), .mode(a_mode), .t_mask(a_mask), .load_val(a_load),
    .clr_ovf(a_clr), .q(a_q), .tc(a_tc), .ovf(a_ovf)
  );

  toggle_counter #(.WIDTH(4), .MODULUS(10), .WRAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .t_mask(b_mask), .load_val(b_load),
    .clr_ovf(b_clr), .q(b_q), .tc(b_tc), .ovf(b_ovf)
  );

  toggle_counter #(.WIDTH(1), .MODULUS(2), .WRAP(1'b1)) dut_c (
    .clk(clk), .rst(rst), .en(c_en), .mode(c_mode), .t_mask(c_mask), .load_val(c_load),
    .clr_ovf(c_clr), .q(c_q), .tc(c_tc), .ovf(c_ovf)
  );

  function automatic step_t mk(logic en, logic [1:0] mode, logic [3:0] mask, logic [3:0] load,
                               logic clr, logic [3:0] q, logic tc, logic ovf);
    step_t s;
    s.en = en; s.mode = mode; s.mask = mask; s.load = load; s.clr = clr;
    s.q = q; s.tc = tc; s.ovf = ovf;
    return s;
  endfunction

  function automatic exp_t expect_of(string tag, int i, step_t s);
    exp_t e;
    e.name = $sformatf("%s[%0d]", tag, i);
    e.q = s.q; e.tc = s.tc; e.ovf = s.ovf;
    return e;
  endfunction

  task automatic apply_a(step_t s);
    a_en = s.en; a_mode = s.mode; a_mask = s.mask; a_load = s.load; a_clr = s.clr;
  endtask

  task automatic apply_b(step_t s);
    b_en = s.en; b_mode = s.mode; b_mask = s.mask; b_load = s.load; b_clr = s.clr;
  endtask

  task automatic apply_c(step_t s);
    c_en = s.en; c_mode = s.mode; c_mask = s.mask[0]; c_load = s.load[0]; c_clr = s.clr;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_en = 1; a_mode = 2'b01; b_en = 1; b_mode = 2'b01; c_en = 1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({a_q, a_tc, a_ovf} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_a: got q=%0d tc=%b ovf=%b, want 0 0 0", a_q, a_tc, a_ovf);
    end
    n_tests++;
    if ({b_q, b_tc, b_ovf} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_b: got q=%0d tc=%b ovf=%b, want 0 0 0", b_q, b_tc, b_ovf);
    end
    n_tests++;
    if ({c_q, c_tc, c_ovf} !== 3'b0) begin
      n_fail++;
      $display("FAIL reset_c: got q=%0d tc=%b ovf=%b, want 0 0 0", c_q, c_tc, c_ovf);
    end
    a_en = 0; b_en = 0; c_en = 0;
    rst = 1'b1;
  endtask

  task automatic test_up_wrap();
    step_t st[$];
    exp_t  e;
    for (int i = 0; i < 12; i++) st.push_back(mk(1, 2'b01, 0, 0, 0, 4'((i + 1) % 10), i == 9, i >= 9));
    for (int i = 0; i < st.size(); i++) begin
      apply_a(st[i]);
      sb.push_back(expect_of("up_wrap", i, st[i]));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({a_q, a_tc, a_ovf} !== {e.q, e.tc, e.ovf}) begin
        n_fail++;
        $display("FAIL %s: got q=%0d tc=%b ovf=%b, want q=%0d tc=%b ovf=%b",
                 e.name, a_q, a_tc, a_ovf, e.q, e.tc, e.ovf);
      end
    end
  endtask

  task automatic test_toggle();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 2'b00, 4'b0000, 0, 1, 2, 0, 0));
    st.push_back(mk(1, 2'b11, 4'b0000, 5, 0, 5, 0, 0));
    st.push_back(mk(1, 2'b00, 4'b0011, 0, 0, 6, 0, 0));
    st.push_back(mk(1, 2'b00, 4'b1100, 0, 0, 9, 0, 1));
    for (int i = 0; i < st.size(); i++) begin
      apply_a(st[i]);
      sb.push_back(expect_of("toggle", i, st[i]));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({a_q, a_tc, a_ovf} !== {e.q, e.tc, e.ovf}) begin
        n_fail++;
        $display("FAIL %s: got q=%0d tc=%b ovf=%b, want q=%0d tc=%b ovf=%b",
                 e.name, a_q, a_tc, a_ovf, e.q, e.tc, e.ovf);
      end
    end
  endtask

  task automatic test_load();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 2'b11, 0, 0,  1, 9, 0, 0));
    st.push_back(mk(1, 2'b11, 0, 7,  0, 7, 0, 0));
    st.push_back(mk(1, 2'b11, 0, 15, 0, 9, 0, 1));
    st.push_back(mk(1, 2'b11, 0, 7,  0, 7, 0, 1));
    st.push_back(mk(0, 2'b11, 0, 0,  1, 7, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      apply_a(st[i]);
      sb.push_back(expect_of("load", i, st[i]));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({a_q, a_tc, a_ovf} !== {e.q, e.tc, e.ovf}) begin
        n_fail++;
        $display("FAIL %s: got q=%0d tc=%b ovf=%b, want q=%0d tc=%b ovf=%b",
                 e.name, a_q, a_tc, a_ovf, e.q, e.tc, e.ovf);
      end
    end
  endtask

  task automatic test_priority_reset();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(1, 2'b11, 0, 9, 0, 9, 0, 0));
    st.push_back(mk(1, 2'b01, 0, 0, 1, 0, 1, 1));
    for (int k = 1; k <= 6; k++) st.push_back(mk(1, 2'b01, 0, 0, 0, 4'(k), 0, 1));
    // Reset is pulsed before step 8 while en/mode still request counting.
    st.push_back(mk(0, 2'b01, 0, 0, 0, 0, 0, 0));
    st.push_back(mk(1, 2'b01, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      if (i == 8) begin
        rst = 1'b0;
        #1;
        n_tests++;
        if ({a_q, a_tc, a_ovf} !== 6'b0) begin
          n_fail++;
          $display("FAIL async_reset: got q=%0d tc=%b ovf=%b, want 0 0 0", a_q, a_tc, a_ovf);
        end
        rst = 1'b1;
      end
      apply_a(st[i]);
      sb.push_back(expect_of("prio_rst", i, st[i]));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({a_q, a_tc, a_ovf} !== {e.q, e.tc, e.ovf}) begin
        n_fail++;
        $display("FAIL %s: got q=%0d tc=%b ovf=%b, want q=%0d tc=%b ovf=%b",
                 e.name, a_q, a_tc, a_ovf, e.q, e.tc, e.ovf);
      end
    end
  endtask

  task automatic test_down_sat();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(1, 2'b11, 0, 1, 0, 1, 0, 0));
    st.push_back(mk(1, 2'b10, 0, 0, 0, 0, 0, 0));
    st.push_back(mk(1, 2'b10, 0, 0, 0, 0, 1, 1));
    st.push_back(mk(1, 2'b10, 0, 0, 0, 0, 1, 1));
    st.push_back(mk(0, 2'b10, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < st.size(); i++) begin
      apply_b(st[i]);
      sb.push_back(expect_of("down_sat", i, st[i]));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({b_q, b_tc, b_ovf} !== {e.q, e.tc, e.ovf}) begin
        n_fail++;
        $display("FAIL %s: got q=%0d tc=%b ovf=%b, want q=%0d tc=%b ovf=%b",
                 e.name, b_q, b_tc, b_ovf, e.q, e.tc, e.ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 2'b01, 0, 0, 1, 0, 0, 0));
    st.push_back(mk(1, 2'b11, 0, 9, 0, 9, 0, 0));
    st.push_back(mk(1, 2'b01, 0, 0, 0, 9, 1, 1));
    st.push_back(mk(1, 2'b01, 0, 0, 0, 9, 1, 1));
    st.push_back(mk(1, 2'b01, 0, 0, 1, 9, 1, 1));
    st.push_back(mk(0, 2'b01, 0, 0, 1, 9, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      apply_b(st[i]);
      sb.push_back(expect_of("b2b_sat", i, st[i]));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({b_q, b_tc, b_ovf} !== {e.q, e.tc, e.ovf}) begin
        n_fail++;
        $display("FAIL %s: got q=%0d tc=%b ovf=%b, want q=%0d tc=%b ovf=%b",
                 e.name, b_q, b_tc, b_ovf, e.q, e.tc, e.ovf);
      end
    end
  endtask

  task automatic test_tff();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(1, 2'b01, 0, 0, 0, 1, 0, 0));
    st.push_back(mk(0, 2'b01, 0, 0, 0, 1, 0, 0));
    st.push_back(mk(1, 2'b01, 0, 0, 0, 0, 1, 1));
    st.push_back(mk(1, 2'b01, 0, 0, 0, 1, 0, 1));
    for (int i = 0; i < st.size(); i++) begin
      apply_c(st[i]);
      sb.push_back(expect_of("tff", i, st[i]));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({3'b000, c_q, c_tc, c_ovf} !== {e.q, e.tc, e.ovf}) begin
        n_fail++;
        $display("FAIL %s: got q=%0d tc=%b ovf=%b, want q=%0d tc=%b ovf=%b",
                 e.name, c_q, c_tc, c_ovf, e.q, e.tc, e.ovf);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_up_wrap();
    test_toggle();
    test_load();
    test_priority_reset();
    test_down_sat();
    test_back_to_back();
    test_tff();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
